memory_cycle: RTL and testbench
===============================

MEMORY_CYCLE -- requirements
Module: memory_cycle

Interface
REQ-001 Parameter: DATA_W, 16, datapath and memory data width.
REQ-002 Parameter: REG_W, 4, destination register index width.
REQ-003 Parameter: TIMEOUT, 15, maximum wait cycles for mem_ack before abort.
REQ-004 Port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 Port: rst  in  1  synchronous, active-low reset.
REQ-006 Port: in_valid  in  1  the execute stage presents a valid instruction.
REQ-007 Port: aluout  in  DATA_W  ALU result, used as memory address or writeback value.
REQ-008 Port: b  in  DATA_W  store data.
REQ-009 Port: rdout  in  REG_W  destination register.
REQ-010 Port: memread / memwrite / regwrite  in  1 each  control bits from the execute stage.
REQ-011 Port: flush  in  1  kill the incoming instruction.
REQ-012 Port: stall_out  out  1  back-pressure to the execute stage.
REQ-013 Port: mem_req / mem_we  out  1 each  data-memory request and write enable.
REQ-014 Port: mem_addr / mem_wdata  out  DATA_W each  request address and write data.
REQ-015 Port: mem_rdata  in  DATA_W  read data, valid with mem_ack.
REQ-016 Port: mem_ack  in  1  memory completion strobe.
REQ-017 Port: wb_valid / wb_regwrite  out  1 each  writeback valid and register-write enable.
REQ-018 Port: wb_rd  out  REG_W  writeback destination.
REQ-019 Port: wb_data  out  DATA_W  writeback value.
REQ-020 Port: mem_err  out  1  one-cycle pulse on a timeout abort.

Function
REQ-021 The FSM SHALL use two states: IDLE and BUSY.
REQ-022 IDLE: an instruction is accepted when in_valid=1, flush=0 and stall_out=0.
REQ-023 Non-memory op SHALL produce wb_valid=1, wb_data=aluout, wb_rd=rdout, wb_regwrite=regwrite one cycle after acceptance; the FSM stays in IDLE.
REQ-024 Memory op SHALL latch addr, data, rd and kind, then enter BUSY with mem_req=1 and mem_addr/mem_wdata/mem_we held stable until mem_ack.
REQ-025 memread=1 and memwrite=1 together SHALL be treated as a write, with wb_regwrite forced to 0.
REQ-026 stall_out SHALL be combinational: 1 in BUSY while mem_ack=0, otherwise 0.
REQ-027 mem_ack in BUSY SHALL return the FSM to IDLE and drop mem_req the next cycle; wb_valid=1 the next cycle; a load SHALL give wb_data=mem_rdata; a store SHALL give wb_regwrite=0.
REQ-028 mem_ack in IDLE SHALL be ignored.
REQ-029 The wait counter SHALL clear on BUSY entry and increment each BUSY cycle without ack; reaching TIMEOUT SHALL abort: IDLE, mem_req=0, mem_err=1 for one cycle, wb_valid=0.
REQ-030 wb_valid SHALL be a one-cycle pulse per completed instruction.
REQ-031 wb_regwrite SHALL be 0 whenever wb_rd=0 (r0 is hardwired).
REQ-032 flush SHALL drop the incoming instruction in IDLE and SHALL be ignored in BUSY (an outstanding access always completes).
REQ-033 Back-to-back: an instruction presented in the ack cycle SHALL be accepted that same edge (stall_out=0).

Reset
REQ-034 rst=0 at a clock edge SHALL force IDLE, counter=0, and all outputs to 0, including mid-access; a late mem_ack SHALL be ignored.

Configuration
REQ-035 Macro MEM_FWD_EN defined: add outputs fwd_valid (1), fwd_rd (REG_W) and fwd_data (DATA_W), equal to wb_valid&wb_regwrite, wb_rd and wb_data, for operand forwarding.
REQ-036 MEM_FWD_EN undefined: these ports are absent and the module's behaviour is otherwise identical.

Structure
REQ-037 Shared package processor_pkg SHALL hold the IDLE/BUSY state encoding, the DATA_W/REG_W defaults and the r0 index constant.
REQ-038 One sub-module, mem_handshake_fsm, SHALL own the state, wait counter, mem_req and the stall/abort logic; the top SHALL own the writeback registers.

Verification
REQ-039 ALU op aluout=0x1234, rdout=3, regwrite=1 -> next cycle wb_valid=1, wb_data=0x1234, wb_rd=3, stall_out never 1.
REQ-040 Load addr 0x0040, ack after 3 cycles with rdata=0xBEEF -> stall_out=1 for 3 cycles, then wb_data=0xBEEF with wb_regwrite=1.
REQ-041 Store addr 0x0010, b=0x00AA, immediate ack -> mem_we=1, mem_wdata=0x00AA, wb_valid=1, wb_regwrite=0.
REQ-042 Load with no ack for TIMEOUT=15 cycles -> mem_err pulse, mem_req=0, no wb_valid.
REQ-043 rst=0 during BUSY, then a stray mem_ack -> all outputs 0, state IDLE, no wb_valid.
REQ-044 ALU op with regwrite=1 and rdout=0 -> wb_regwrite=0; with MEM_FWD_EN, fwd_valid=0.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared definitions for the memory stage: FSM state encoding, default widths
// and the hardwired-zero register index.
package processor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int R0_IDX     = 0;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory handshake controller: IDLE/BUSY state, wait counter, request,
// back-pressure and timeout abort.
module mem_handshake_fsm
  import processor_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic mem_ack,
  output logic mem_req,
  output logic stall_out,
  output logic done,
  output logic mem_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               abort;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      mem_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      mem_err <= abort;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    abort     = 1'b0;
    done      = 1'b0;
    stall_out = 1'b0;
    mem_req   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = '0;
        end
      end
      BUSY: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          done    = 1'b1;
          cnt_nxt = '0;
          // A memory op accepted in the ack cycle keeps the request up
          if (!start) state_nxt = IDLE;
        end else begin
          stall_out = 1'b1;
          if (cnt == CNT_W'(TIMEOUT - 1)) begin
            abort     = 1'b1;
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/memory_cycle.sv
// Memory pipeline stage: issues loads/stores and owns the writeback registers.
// Optional macro MEM_FWD_EN adds fwd_valid/fwd_rd/fwd_data forwarding outputs.
module memory_cycle
  import processor_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int REG_W   = REG_W_DEF,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] aluout,
  input  logic [DATA_W-1:0] b,
  input  logic [REG_W-1:0]  rdout,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              regwrite,
  input  logic              flush,
  output logic              stall_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
`ifdef MEM_FWD_EN
  ,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_rd,
  output logic [DATA_W-1:0] fwd_data
`endif
);

  logic              is_mem, accept, start, done, alu_acc, alu_rw, push;
  logic              we_p1, rw_p1;
  logic [REG_W-1:0]  rd_p1;
  logic              pend_vld_p1, pend_rw_p1;
  logic [REG_W-1:0]  pend_rd_p1;
  logic [DATA_W-1:0] pend_data_p1;
  logic              nxt_vld, nxt_rw;
  logic [REG_W-1:0]  nxt_rd;
  logic [DATA_W-1:0] nxt_data;

  assign is_mem  = memread | memwrite;
  assign accept  = in_valid & ~flush & ~stall_out;
  assign start   = accept & is_mem;
  assign alu_acc = accept & ~is_mem;
  assign alu_rw  = regwrite & (rdout != REG_W'(R0_IDX));
  // An ALU op accepted while an older result is leaving waits one slot
  assign push    = alu_acc & (done | pend_vld_p1);

  mem_handshake_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mem_ack  (mem_ack),
    .mem_req  (mem_req),
    .stall_out(stall_out),
    .done     (done),
    .mem_err  (mem_err)
  );

  assign mem_we = mem_req & we_p1;

  always_comb begin
    nxt_vld  = 1'b0;
    nxt_rw   = 1'b0;
    nxt_rd   = wb_rd;
    nxt_data = wb_data;
    if (done) begin
      nxt_vld  = 1'b1;
      nxt_rw   = rw_p1;
      nxt_rd   = rd_p1;
      nxt_data = we_p1 ? mem_wdata : mem_rdata;
    end else if (pend_vld_p1) begin
      nxt_vld  = 1'b1;
      nxt_rw   = pend_rw_p1;
      nxt_rd   = pend_rd_p1;
      nxt_data = pend_data_p1;
    end else if (alu_acc) begin
      nxt_vld  = 1'b1;
      nxt_rw   = alu_rw;
      nxt_rd   = rdout;
      nxt_data = aluout;
    end
  end

  // Stage p1: latched memory op and writeback registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_addr    <= '0;
      mem_wdata   <= '0;
      we_p1       <= 1'b0;
      rw_p1       <= 1'b0;
      rd_p1       <= '0;
      pend_vld_p1 <= 1'b0;
      wb_valid    <= 1'b0;
      wb_regwrite <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
    end else begin
      if (start) begin
        mem_addr  <= aluout;
        mem_wdata <= b;
        we_p1     <= memwrite;
        rw_p1     <= alu_rw & ~memwrite;
        rd_p1     <= rdout;
      end
      pend_vld_p1 <= push;
      wb_valid    <= nxt_vld;
      wb_regwrite <= nxt_rw;
      wb_rd       <= nxt_rd;
      wb_data     <= nxt_data;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pend_rw_p1   <= alu_rw;
      pend_rd_p1   <= rdout;
      pend_data_p1 <= aluout;
    end
  end

`ifdef MEM_FWD_EN
  assign fwd_valid = wb_valid & wb_regwrite;
  assign fwd_rd    = wb_rd;
  assign fwd_data  = wb_data;
`endif

endmodule

// File: tb/tb_memory_cycle.sv
// Bench for memory_cycle: directed scenarios plus randomized traffic against a
// transaction-level model of the memory stage.
module tb_memory_cycle;

  localparam int DATA_W  = 16;
  localparam int REG_W   = 4;
  localparam int TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid, memread, memwrite, regwrite, flush, mem_ack;
  logic [DATA_W-1:0] aluout, b, mem_rdata;
  logic [REG_W-1:0]  rdout;
  logic              stall_out, mem_req, mem_we, wb_valid, wb_regwrite, mem_err;
  logic [DATA_W-1:0] mem_addr, mem_wdata, wb_data;
  logic [REG_W-1:0]  wb_rd;
`ifdef MEM_FWD_EN
  logic              fwd_valid;
  logic [REG_W-1:0]  fwd_rd;
  logic [DATA_W-1:0] fwd_data;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              rw;
    logic              chk;
  } res_t;

  res_t exp_q[$];

  memory_cycle #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .aluout(aluout), .b(b), .rdout(rdout),
    .memread(memread), .memwrite(memwrite), .regwrite(regwrite), .flush(flush),
    .stall_out(stall_out), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .mem_err(mem_err)
`ifdef MEM_FWD_EN
    , .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
`endif
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    in_valid = 0; flush = 0; memread = 0; memwrite = 0; regwrite = 0;
    aluout = 0; b = 0; rdout = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic present(input logic rd_i, input logic wr_i, input logic rw_i,
                         input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] bv,
                         input logic [REG_W-1:0] rd);
    in_valid = 1; flush = 0; memread = rd_i; memwrite = wr_i; regwrite = rw_i;
    aluout = a; b = bv; rdout = rd;
  endtask

  task automatic test_reset();
    logic [57:0] outs;
    rst = 0; mem_ack = 1;
    cyc(); cyc();
    mem_ack = 0; #1;
    outs = {wb_valid, wb_regwrite, wb_rd, wb_data, mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall_out};
    n_checks++; if (outs !== 58'd0) $display("FAIL reset_outputs got %h want 0", outs); else n_pass++;
    rst = 1;
  endtask

  task automatic test_alu();
    present(0, 0, 1, 16'h1234, 16'h0, 4'd3); #1;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL alu_stall got %b want 0", stall_out); else n_pass++;
    cyc(); idle_in();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL alu_wb_valid got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (wb_data !== 16'h1234) $display("FAIL alu_wb_data got %h want 1234", wb_data); else n_pass++;
    n_checks++; if (wb_rd !== 4'd3) $display("FAIL alu_wb_rd got %0d want 3", wb_rd); else n_pass++;
    n_checks++; if (wb_regwrite !== 1'b1) $display("FAIL alu_wb_regwrite got %b want 1", wb_regwrite); else n_pass++;
`ifdef MEM_FWD_EN
    n_checks++; if ({fwd_valid, fwd_rd, fwd_data} !== {1'b1, 4'd3, 16'h1234})
      $display("FAIL alu_fwd got %b/%0d/%h want 1/3/1234", fwd_valid, fwd_rd, fwd_data); else n_pass++;
`endif
    n_checks++; if (stall_out !== 1'b0) $display("FAIL alu_stall_after got %b want 0", stall_out); else n_pass++;
    cyc();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL alu_wb_pulse got %b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_load();
    int stalls = 0;
    present(1, 0, 1, 16'h0040, 16'h0, 4'd5);
    cyc(); idle_in();
    for (int i = 0; i < 3; i++) begin
      if (stall_out === 1'b1) stalls++;
      n_checks++; if ({mem_req, mem_we, mem_addr} !== {1'b1, 1'b0, 16'h0040})
        $display("FAIL load_req got %b/%b/%h want 1/0/0040", mem_req, mem_we, mem_addr); else n_pass++;
      cyc();
    end
    mem_ack = 1; mem_rdata = 16'hBEEF; #1;
    if (stall_out === 1'b1) stalls++;
    n_checks++; if (stalls !== 3) $display("FAIL load_stall_cycles got %0d want 3", stalls); else n_pass++;
    cyc(); idle_in();
    n_checks++; if (wb_valid !== 1'b1) $display("FAIL load_wb_valid got %b want 1", wb_valid); else n_pass++;
    n_checks++; if (wb_data !== 16'hBEEF) $display("FAIL load_wb_data got %h want beef", wb_data); else n_pass++;
    n_checks++; if ({wb_regwrite, wb_rd} !== {1'b1, 4'd5}) $display("FAIL load_wb_rw_rd got %b/%0d want 1/5", wb_regwrite, wb_rd); else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL load_req_drop got %b want 0", mem_req); else n_pass++;
    cyc();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL load_wb_pulse got %b want 0", wb_valid); else n_pass++;
  endtask

  task automatic test_store();
    present(0, 1, 1, 16'h0010, 16'h00AA, 4'd7);
    cyc(); idle_in();
    mem_ack = 1; #1;
    n_checks++; if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 16'h0010, 16'h00AA})
      $display("FAIL store_req got %b/%b/%h/%h want 1/1/0010/00aa", mem_req, mem_we, mem_addr, mem_wdata); else n_pass++;
    cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_regwrite} !== 2'b10) $display("FAIL store_wb got %b%b want 10", wb_valid, wb_regwrite); else n_pass++;
    // memread and memwrite together behave as a store
    present(1, 1, 1, 16'h0022, 16'h0055, 4'd9);
    cyc(); idle_in();
    n_checks++; if (mem_we !== 1'b1) $display("FAIL rw_both_we got %b want 1", mem_we); else n_pass++;
    mem_ack = 1; cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_regwrite} !== 2'b10) $display("FAIL rw_both_wb got %b%b want 10", wb_valid, wb_regwrite); else n_pass++;
  endtask

  task automatic test_timeout();
    int wbs = 0;
    present(1, 0, 1, 16'h0080, 16'h0, 4'd2);
    cyc(); idle_in();
    for (int i = 0; i < TIMEOUT; i++) begin
      n_checks++; if ({mem_req, mem_err} !== 2'b10) $display("FAIL timeout_wait%0d got %b%b want 10", i, mem_req, mem_err); else n_pass++;
      if (wb_valid === 1'b1) wbs++;
      cyc();
    end
    n_checks++; if ({mem_err, mem_req, wb_valid} !== 3'b100) $display("FAIL timeout_abort got %b%b%b want 100", mem_err, mem_req, wb_valid); else n_pass++;
    mem_ack = 1; mem_rdata = 16'h5A5A;
    cyc(); idle_in();
    if (wb_valid === 1'b1) wbs++;
    n_checks++; if ({mem_err, mem_req} !== 2'b00) $display("FAIL timeout_err_pulse got %b%b want 00", mem_err, mem_req); else n_pass++;
    cyc();
    if (wb_valid === 1'b1) wbs++;
    n_checks++; if (wbs !== 0) $display("FAIL timeout_no_wb got %0d want 0", wbs); else n_pass++;
  endtask

  task automatic test_reset_busy();
    logic [57:0] outs;
    present(1, 0, 1, 16'h00F0, 16'h0, 4'd6);
    cyc(); idle_in(); cyc();
    rst = 0; cyc(); rst = 1;
    mem_ack = 1; mem_rdata = 16'h7777; #1;
    outs = {wb_valid, wb_regwrite, wb_rd, wb_data, mem_req, mem_we, mem_addr, mem_wdata, mem_err, stall_out};
    n_checks++; if (outs !== 58'd0) $display("FAIL rstbusy_outputs got %h want 0", outs); else n_pass++;
    cyc(); idle_in();
    n_checks++; if ({wb_valid, mem_req, mem_err, wb_data} !== 19'd0)
      $display("FAIL rstbusy_stray_ack got %b/%b/%b/%h want 0", wb_valid, mem_req, mem_err, wb_data); else n_pass++;
  endtask

  task automatic test_r0();
    present(0, 0, 1, 16'hCAFE, 16'h0, 4'd0);
    cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_regwrite} !== 2'b10) $display("FAIL r0_wb got %b%b want 10", wb_valid, wb_regwrite); else n_pass++;
`ifdef MEM_FWD_EN
    n_checks++; if (fwd_valid !== 1'b0) $display("FAIL r0_fwd_valid got %b want 0", fwd_valid); else n_pass++;
`endif
    cyc();
  endtask

  task automatic test_flush();
    present(0, 0, 1, 16'h1111, 16'h0, 4'd4); flush = 1;
    cyc(); idle_in();
    n_checks++; if (wb_valid !== 1'b0) $display("FAIL flush_idle got %b want 0", wb_valid); else n_pass++;
    present(1, 0, 1, 16'h0044, 16'h0, 4'd8);
    cyc(); idle_in();
    flush = 1; mem_ack = 1; mem_rdata = 16'h4242;
    cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_data} !== {1'b1, 16'h4242}) $display("FAIL flush_busy got %b/%h want 1/4242", wb_valid, wb_data); else n_pass++;
    mem_ack = 1; cyc(); idle_in();
    n_checks++; if ({wb_valid, mem_req} !== 2'b00) $display("FAIL ack_idle got %b%b want 00", wb_valid, mem_req); else n_pass++;
  endtask

  task automatic test_back_to_back();
    present(1, 0, 1, 16'h0020, 16'h0, 4'd2);
    cyc();
    present(1, 0, 1, 16'h0030, 16'h0, 4'd4);
    mem_ack = 1; mem_rdata = 16'h1111; #1;
    n_checks++; if (stall_out !== 1'b0) $display("FAIL b2b_stall got %b want 0", stall_out); else n_pass++;
    cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_rd, wb_data} !== {1'b1, 4'd2, 16'h1111}) $display("FAIL b2b_first_wb got %b/%0d/%h want 1/2/1111", wb_valid, wb_rd, wb_data); else n_pass++;
    n_checks++; if ({mem_req, mem_addr} !== {1'b1, 16'h0030}) $display("FAIL b2b_second_req got %b/%h want 1/0030", mem_req, mem_addr); else n_pass++;
    mem_ack = 1; mem_rdata = 16'h2222;
    cyc(); idle_in();
    n_checks++; if ({wb_valid, wb_rd, wb_data, mem_req} !== {1'b1, 4'd4, 16'h2222, 1'b0}) $display("FAIL b2b_second_wb got %b/%0d/%h/%b want 1/4/2222/0", wb_valid, wb_rd, wb_data, mem_req); else n_pass++;
    cyc();
  endtask

  task automatic test_random(input int ncyc);
    logic ov = 0, ost = 0, orw = 0, exp_err = 0, drain, acc_ok;
    logic [DATA_W-1:0] oaddr = 0, ob = 0;
    logic [REG_W-1:0] ord = 0;
    int owait = 0, ackp, kind;
    res_t r;
    exp_q.delete();
    for (int c = 0; c < ncyc + 30; c++) begin
      drain = (c >= ncyc);
      n_checks++; if (mem_err !== exp_err) $display("FAIL rand_mem_err c%0d got %b want %b", c, mem_err, exp_err); else n_pass++;
      if (wb_valid === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL rand_wb_extra c%0d got wb_valid 1 want none", c);
        else begin
          n_pass++;
          r = exp_q.pop_front();
          n_checks++; if (wb_regwrite !== r.rw) $display("FAIL rand_wb_rw c%0d got %b want %b", c, wb_regwrite, r.rw); else n_pass++;
          if (r.chk) begin
            n_checks++; if ({wb_rd, wb_data} !== {r.rd, r.data}) $display("FAIL rand_wb_data c%0d got %0d/%h want %0d/%h", c, wb_rd, wb_data, r.rd, r.data); else n_pass++;
          end
        end
      end
      ackp = ((c % 400) < 100) ? 4 : 45;
      kind = $urandom_range(0, 3);
      in_valid = !drain && ($urandom_range(0, 9) < 6);
      flush = ($urandom_range(0, 9) == 0);
      memread = (kind == 1) || (kind == 3);
      memwrite = (kind >= 2);
      regwrite = $urandom_range(0, 1);
      rdout = REG_W'($urandom_range(0, 15));
      aluout = DATA_W'($urandom); b = DATA_W'($urandom); mem_rdata = DATA_W'($urandom);
      mem_ack = ov ? (drain || ($urandom_range(0, 99) < ackp)) : ($urandom_range(0, 19) == 0);
      #1;
      n_checks++; if (mem_req !== ov) $display("FAIL rand_mem_req c%0d got %b want %b", c, mem_req, ov); else n_pass++;
      n_checks++; if (stall_out !== (ov && !mem_ack)) $display("FAIL rand_stall c%0d got %b want %b", c, stall_out, ov && !mem_ack); else n_pass++;
      if (ov) begin
        n_checks++;
        if ({mem_addr, mem_we} !== {oaddr, ost} || (ost && mem_wdata !== ob))
          $display("FAIL rand_req_fields c%0d got %h/%b/%h want %h/%b/%h", c, mem_addr, mem_we, mem_wdata, oaddr, ost, ob);
        else n_pass++;
      end
      exp_err = 0;
      acc_ok = !ov || mem_ack;
      if (ov) begin
        if (mem_ack) begin
          r.data = ost ? '0 : mem_rdata; r.rd = ord; r.rw = orw; r.chk = !ost;
          exp_q.push_back(r);
          ov = 0;
        end else begin
          owait++;
          if (owait == TIMEOUT) begin ov = 0; exp_err = 1; end
        end
      end
      if (in_valid && !flush && acc_ok) begin
        if (memread || memwrite) begin
          ov = 1; ost = memwrite; oaddr = aluout; ob = b; ord = rdout; owait = 0;
          orw = !memwrite && regwrite && (rdout != 0);
        end else begin
          r.data = aluout; r.rd = rdout; r.rw = regwrite && (rdout != 0); r.chk = 1;
          exp_q.push_back(r);
        end
      end
      cyc();
    end
    idle_in();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rand_drain got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    idle_in();
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_timeout();
    test_reset_busy();
    test_r0();
    test_flush();
    test_back_to_back();
    test_random(3000);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
